axi_rd_line_collector: RTL and testbench

Sits directly downstream of the AXI shim's read channel, between the cache refill logic and the shim. It takes one read request from the cache miss unit, registers it, and drives the shim's read-request handshake. It then sinks every response beat (single or burst) into a line buffer and presents the whole line to the consumer in one valid/ready transfer. Only one transaction is outstanding at a time.

---
 rtl/axi_rd_collect_pkg.sv | 28 ++
 rtl/axi_rd_line_buf.sv | 35 +++
 rtl/axi_rd_line_collector.sv | 156 +++++++++++++++
 tb/tb_axi_rd_line_collector.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_collect_pkg.sv
// Shared types for the AXI read line collector: FSM states, request record, index width.
// Default geometry lives here so the record width and the collector ports always agree.
package axi_rd_collect_pkg;

  localparam int unsigned NumWords  = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 64;
  localparam int unsigned IdWidth   = 4;

  localparam int unsigned IdxWidth  = (NumWords > 1) ? $clog2(NumWords) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DONE
  } state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [IdxWidth-1:0]  blen;
    logic [2:0]           size;
    logic [IdWidth-1:0]   id;
    logic                 lock;
  } rd_req_t;

endpackage

// File: rtl/axi_rd_line_buf.sv
// Line buffer: one indexed beat write per cycle, synchronous clear, full-width read.
module axi_rd_line_buf #(
  parameter int unsigned NumWords  = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned UserWidth = 64,
  parameter int unsigned IdxWidth  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr,
  input  logic                          we,
  input  logic [IdxWidth-1:0]           idx,
  input  logic [DataWidth-1:0]          wdata,
  input  logic [UserWidth-1:0]          wuser,
  output logic [NumWords*DataWidth-1:0] line_data,
  output logic [NumWords*UserWidth-1:0] line_user
);

  logic [NumWords-1:0][DataWidth-1:0] data_q;
  logic [NumWords-1:0][UserWidth-1:0] user_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      data_q <= '0;
      user_q <= '0;
    end else if (we) begin
      data_q[idx] <= wdata;
      user_q[idx] <= wuser;
    end
  end

  assign line_data = data_q;
  assign line_user = user_q;

endmodule

// File: rtl/axi_rd_line_collector.sv
// Issues one AXI read, sinks its beats into a line buffer and hands the line out in one transfer.
// Optional macro AXI_RD_COLLECT_IDCHK_EN: beats with a foreign ID are sunk but ignored and flag an error.
module axi_rd_line_collector
  import axi_rd_collect_pkg::*;
#(
  parameter int unsigned AxiNumWords  = NumWords,
  parameter int unsigned AxiAddrWidth = AddrWidth,
  parameter int unsigned AxiDataWidth = DataWidth,
  parameter int unsigned AxiUserWidth = UserWidth,
  parameter int unsigned AxiIdWidth   = IdWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_i,
  output logic                             gnt_o,
  input  logic [AxiAddrWidth-1:0]          addr_i,
  input  logic [IdxWidth-1:0]              blen_i,
  input  logic [2:0]                       size_i,
  input  logic [AxiIdWidth-1:0]            id_i,
  input  logic                             lock_i,
  output logic                             rd_req_o,
  input  logic                             rd_gnt_i,
  output logic [AxiAddrWidth-1:0]          rd_addr_o,
  output logic [IdxWidth-1:0]              rd_blen_o,
  output logic [2:0]                       rd_size_o,
  output logic [AxiIdWidth-1:0]            rd_id_o,
  output logic                             rd_lock_o,
  output logic                             rd_rdy_o,
  input  logic                             rd_valid_i,
  input  logic                             rd_last_i,
  input  logic [AxiDataWidth-1:0]          rd_data_i,
  input  logic [AxiUserWidth-1:0]          rd_user_i,
  input  logic [AxiIdWidth-1:0]            rd_id_i,
  input  logic                             rd_exokay_i,
  output logic                             line_valid_o,
  input  logic                             line_ready_i,
  output logic [AxiNumWords*AxiDataWidth-1:0] line_data_o,
  output logic [AxiNumWords*AxiUserWidth-1:0] line_user_o,
  output logic [AxiIdWidth-1:0]            line_id_o,
  output logic                             line_exokay_o,
  output logic                             line_err_o
);

  // The request record is shared through the package, so the geometry must match it.
  if (AxiNumWords != NumWords || AxiAddrWidth != AddrWidth || AxiDataWidth != DataWidth ||
      AxiUserWidth != UserWidth || AxiIdWidth != IdWidth) begin : g_param_check
    $error("axi_rd_line_collector parameters must match axi_rd_collect_pkg geometry");
  end

  // One extra bit so the beat counter can saturate at AxiNumWords.
  localparam int unsigned CntWidth = IdxWidth + 1;

  state_e              state_q;
  rd_req_t             req_q;
  logic [CntWidth-1:0] cnt_q;
  logic                exokay_q;
  logic                err_q;

  logic                id_ok;
  logic [CntWidth-1:0] blen_ext;
  logic                in_range;
  logic                buf_we;
  logic                buf_clr;

`ifdef AXI_RD_COLLECT_IDCHK_EN
  assign id_ok = (rd_id_i == req_q.id);
`else
  logic unused_rd_id;
  assign unused_rd_id = ^rd_id_i;
  assign id_ok        = 1'b1;
`endif

  assign blen_ext = {1'b0, req_q.blen};
  assign in_range = (cnt_q <= blen_ext);
  assign buf_we   = (state_q == COLLECT) && rd_valid_i && id_ok && in_range;
  assign buf_clr  = (state_q == IDLE) && req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      exokay_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            req_q    <= '{addr: addr_i, blen: blen_i, size: size_i, id: id_i, lock: lock_i};
            exokay_q <= lock_i;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (rd_gnt_i) begin
            cnt_q   <= '0;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (rd_valid_i) begin
            if (!id_ok) begin
              err_q <= 1'b1;
            end else begin
              // Beats past the requested length are sunk and dropped.
              if (!in_range) err_q <= 1'b1;
              if (cnt_q != CntWidth'(AxiNumWords)) cnt_q <= cnt_q + 1'b1;
              exokay_q <= exokay_q & rd_exokay_i;
              if (rd_last_i) begin
                if (cnt_q != blen_ext) err_q <= 1'b1;
                state_q <= DONE;
              end
            end
          end
        end
        DONE: begin
          if (line_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axi_rd_line_buf #(
    .NumWords (AxiNumWords),
    .DataWidth(AxiDataWidth),
    .UserWidth(AxiUserWidth),
    .IdxWidth (IdxWidth)
  ) u_line_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr      (buf_clr),
    .we       (buf_we),
    .idx      (cnt_q[IdxWidth-1:0]),
    .wdata    (rd_data_i),
    .wuser    (rd_user_i),
    .line_data(line_data_o),
    .line_user(line_user_o)
  );

  assign gnt_o         = (state_q == IDLE) && req_i && !rst_i;
  assign rd_req_o      = (state_q == REQ);
  assign rd_addr_o     = req_q.addr;
  assign rd_blen_o     = req_q.blen;
  assign rd_size_o     = req_q.size;
  assign rd_id_o       = req_q.id;
  assign rd_lock_o     = req_q.lock;
  assign rd_rdy_o      = (state_q == COLLECT);
  assign line_valid_o  = (state_q == DONE);
  assign line_id_o     = req_q.id;
  assign line_exokay_o = exokay_q;
  assign line_err_o    = err_q;

endmodule

// File: tb/tb_axi_rd_line_collector.sv
// Randomized bench for axi_rd_line_collector against a beat-list reference model.
module tb_axi_rd_line_collector;

  logic         clk;
  logic         rst_i;
  logic         req_i;
  logic         gnt_o;
  logic [63:0]  addr_i;
  logic [1:0]   blen_i;
  logic [2:0]   size_i;
  logic [3:0]   id_i;
  logic         lock_i;
  logic         rd_req_o;
  logic         rd_gnt_i;
  logic [63:0]  rd_addr_o;
  logic [1:0]   rd_blen_o;
  logic [2:0]   rd_size_o;
  logic [3:0]   rd_id_o;
  logic         rd_lock_o;
  logic         rd_rdy_o;
  logic         rd_valid_i;
  logic         rd_last_i;
  logic [63:0]  rd_data_i;
  logic [63:0]  rd_user_i;
  logic [3:0]   rd_id_i;
  logic         rd_exokay_i;
  logic         line_valid_o;
  logic         line_ready_i;
  logic [255:0] line_data_o;
  logic [255:0] line_user_o;
  logic [3:0]   line_id_o;
  logic         line_exokay_o;
  logic         line_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0]  q_data[$];
  logic [63:0]  q_user[$];
  logic         q_ex[$];
  logic         q_last[$];
  logic [3:0]   q_id[$];

  logic [255:0] exp_data;
  logic [255:0] exp_user;
  logic         exp_ex;
  logic         exp_err;

  axi_rd_line_collector dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .blen_i(blen_i), .size_i(size_i), .id_i(id_i), .lock_i(lock_i),
    .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o), .rd_blen_o(rd_blen_o),
    .rd_size_o(rd_size_o), .rd_id_o(rd_id_o), .rd_lock_o(rd_lock_o), .rd_rdy_o(rd_rdy_o),
    .rd_valid_i(rd_valid_i), .rd_last_i(rd_last_i), .rd_data_i(rd_data_i), .rd_user_i(rd_user_i),
    .rd_id_i(rd_id_i), .rd_exokay_i(rd_exokay_i), .line_valid_o(line_valid_o),
    .line_ready_i(line_ready_i), .line_data_o(line_data_o), .line_user_o(line_user_o),
    .line_id_o(line_id_o), .line_exokay_o(line_exokay_o), .line_err_o(line_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    q_data.delete(); q_user.delete(); q_ex.delete(); q_last.delete(); q_id.delete();
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [63:0] u, input logic ex,
                           input logic last, input logic [3:0] id);
    q_data.push_back(d); q_user.push_back(u); q_ex.push_back(ex);
    q_last.push_back(last); q_id.push_back(id);
  endtask

  // Expected line from the beat list: beat k fills slot k up to blen, the first
  // accepted last beat closes the line, exokay is the AND over accepted beats.
  task automatic model(input logic [1:0] bl, input logic [3:0] id, input logic lk);
    int k;
    k = 0;
    exp_data = '0; exp_user = '0; exp_ex = lk; exp_err = 1'b0;
    for (int i = 0; i < q_data.size(); i++) begin
`ifdef AXI_RD_COLLECT_IDCHK_EN
      if (q_id[i] != id) begin
        exp_err = 1'b1;
        continue;
      end
`endif
      if (k <= int'(bl)) begin
        exp_data[k*64 +: 64] = q_data[i];
        exp_user[k*64 +: 64] = q_user[i];
      end else begin
        exp_err = 1'b1;
      end
      exp_ex = exp_ex & q_ex[i];
      if (q_last[i]) begin
        if (k != int'(bl)) exp_err = 1'b1;
        break;
      end
      if (k < 4) k++;
    end
  endtask

  task automatic check_line(input string nm, input logic [3:0] id);
    n_tests++; if (line_data_o !== exp_data) begin n_fail++; $display("FAIL %s data: got %0h expected %0h", nm, line_data_o, exp_data); end
    n_tests++; if (line_user_o !== exp_user) begin n_fail++; $display("FAIL %s user: got %0h expected %0h", nm, line_user_o, exp_user); end
    n_tests++; if ({line_id_o, line_exokay_o, line_err_o} !== {id, exp_ex, exp_err}) begin
      n_fail++; $display("FAIL %s id/exokay/err: got %0h/%0b/%0b expected %0h/%0b/%0b", nm, line_id_o, line_exokay_o, line_err_o, id, exp_ex, exp_err);
    end
  endtask

  task automatic run_txn(input string nm, input logic [63:0] a, input logic [1:0] bl, input logic [2:0] sz,
                         input logic [3:0] id, input logic lk, input int gdly, input int rdly, input bit leave_done);
    model(bl, id, lk);
    addr_i = a; blen_i = bl; size_i = sz; id_i = id; lock_i = lk; req_i = 1'b1;
    #1;
    n_tests++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL %s gnt in idle: got %0b expected 1", nm, gnt_o); end
    tick();
    req_i = 1'b0;
    addr_i = {$urandom, $urandom}; blen_i = 2'($urandom); size_i = 3'($urandom); id_i = 4'($urandom); lock_i = 1'($urandom);
    for (int c = 0; c <= gdly; c++) begin
      rd_gnt_i = (c == gdly);
      #1;
      n_tests++; if ({rd_req_o, rd_addr_o, rd_blen_o, rd_size_o, rd_id_o, rd_lock_o} !== {1'b1, a, bl, sz, id, lk}) begin
        n_fail++; $display("FAIL %s rd request cyc %0d: got req=%0b addr=%0h blen=%0d id=%0h expected req=1 addr=%0h blen=%0d id=%0h",
                           nm, c, rd_req_o, rd_addr_o, rd_blen_o, rd_id_o, a, bl, id);
      end
      tick();
    end
    rd_gnt_i = 1'b0;
    for (int i = 0; i < q_data.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        rd_valid_i = 1'b0;
        #1;
        n_tests++; if ({rd_rdy_o, line_valid_o} !== 2'b10) begin n_fail++; $display("FAIL %s collect gap: got rdy=%0b valid=%0b expected rdy=1 valid=0", nm, rd_rdy_o, line_valid_o); end
        tick();
      end
      rd_valid_i = 1'b1; rd_data_i = q_data[i]; rd_user_i = q_user[i];
      rd_exokay_i = q_ex[i]; rd_last_i = q_last[i]; rd_id_i = q_id[i];
      #1;
      n_tests++; if (rd_rdy_o !== 1'b1) begin n_fail++; $display("FAIL %s beat %0d rdy: got %0b expected 1", nm, i, rd_rdy_o); end
      tick();
    end
    rd_valid_i = 1'b0; rd_last_i = 1'b0;
    #1;
    n_tests++; if (line_valid_o !== 1'b1) begin n_fail++; $display("FAIL %s line valid after last: got %0b expected 1", nm, line_valid_o); end
    check_line(nm, id);
    for (int c = 0; c < rdly; c++) begin
      line_ready_i = 1'b0; req_i = 1'b1; addr_i = {$urandom, $urandom};
      #1;
      n_tests++; if ({line_valid_o, gnt_o, rd_rdy_o} !== 3'b100) begin
        n_fail++; $display("FAIL %s done hold cyc %0d: got valid=%0b gnt=%0b rdy=%0b expected valid=1 gnt=0 rdy=0", nm, c, line_valid_o, gnt_o, rd_rdy_o);
      end
      check_line(nm, id);
      tick();
    end
    req_i = 1'b0;
    if (!leave_done) begin
      line_ready_i = 1'b1; req_i = 1'b1;
      #1;
      n_tests++; if ({line_valid_o, gnt_o} !== 2'b10) begin n_fail++; $display("FAIL %s ready cycle: got valid=%0b gnt=%0b expected valid=1 gnt=0", nm, line_valid_o, gnt_o); end
      tick();
      req_i = 1'b0; line_ready_i = 1'b0;
      #1;
      n_tests++; if ({line_valid_o, rd_req_o} !== 2'b00) begin n_fail++; $display("FAIL %s after handoff: got valid=%0b rd_req=%0b expected 0/0", nm, line_valid_o, rd_req_o); end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b0; rd_gnt_i = 1'b0; rd_valid_i = 1'b0; rd_last_i = 1'b0;
    line_ready_i = 1'b0; addr_i = '0; blen_i = '0; size_i = '0; id_i = '0; lock_i = 1'b0;
    rd_data_i = '0; rd_user_i = '0; rd_id_i = '0; rd_exokay_i = 1'b0;
    repeat (3) tick();
    n_tests++; if ({gnt_o, rd_req_o, rd_addr_o, rd_blen_o, rd_size_o, rd_id_o, rd_lock_o, rd_rdy_o} !== '0) begin
      n_fail++; $display("FAIL reset rd side: got gnt=%0b req=%0b addr=%0h rdy=%0b expected all 0", gnt_o, rd_req_o, rd_addr_o, rd_rdy_o);
    end
    n_tests++; if ({line_valid_o, line_data_o, line_user_o, line_id_o, line_exokay_o, line_err_o} !== '0) begin
      n_fail++; $display("FAIL reset line side: got valid=%0b data=%0h err=%0b expected all 0", line_valid_o, line_data_o, line_err_o);
    end
    req_i = 1'b1;
    #1;
    n_tests++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset gnt with req: got %0b expected 0", gnt_o); end
    req_i = 1'b0;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_burst4();
    clear_beats();
    push_beat(64'h11, {$urandom, $urandom}, 1'($urandom), 1'b0, 4'h1);
    push_beat(64'h22, {$urandom, $urandom}, 1'($urandom), 1'b0, 4'h1);
    push_beat(64'h33, {$urandom, $urandom}, 1'($urandom), 1'b0, 4'h1);
    push_beat(64'h44, {$urandom, $urandom}, 1'($urandom), 1'b1, 4'h1);
    run_txn("burst4", 64'h1000, 2'd3, 3'd3, 4'h1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_single();
    clear_beats();
    push_beat(64'hAB, 64'hCD, 1'b1, 1'b1, 4'h6);
    run_txn("single", 64'h2040, 2'd0, 3'd3, 4'h6, 1'b0, 5, 2, 1'b0);
  endtask

  task automatic test_exclusive();
    logic ex_pat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    clear_beats();
    for (int i = 0; i < 4; i++) push_beat({$urandom, $urandom}, {$urandom, $urandom}, ex_pat[i], i == 3, 4'h3);
    run_txn("excl_fail", 64'h3000, 2'd3, 3'd3, 4'h3, 1'b1, 1, 0, 1'b0);
    clear_beats();
    for (int i = 0; i < 4; i++) push_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, i == 3, 4'h3);
    run_txn("excl_ok", 64'h3040, 2'd3, 3'd3, 4'h3, 1'b1, 0, 1, 1'b0);
  endtask

  task automatic test_short_long();
    clear_beats();
    push_beat(64'hA1, 64'h1, 1'b1, 1'b0, 4'h2);
    push_beat(64'hA2, 64'h2, 1'b1, 1'b1, 4'h2);
    run_txn("short", 64'h4000, 2'd3, 3'd3, 4'h2, 1'b0, 0, 10, 1'b0);
    clear_beats();
    for (int i = 0; i < 6; i++) push_beat(64'hB0 + 64'(i), 64'(i), 1'b1, i == 5, 4'h2);
    run_txn("long", 64'h4040, 2'd1, 3'd3, 4'h2, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_req_during_done();
    clear_beats();
    push_beat(64'hC1, 64'h9, 1'b0, 1'b1, 4'h4);
    run_txn("done_req", 64'h5000, 2'd0, 3'd2, 4'h4, 1'b0, 0, 3, 1'b1);
    addr_i = 64'h5100; blen_i = 2'd0; size_i = 3'd3; id_i = 4'h5; lock_i = 1'b0; req_i = 1'b1;
    line_ready_i = 1'b1;
    #1;
    n_tests++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL done_req gnt with ready: got %0b expected 0", gnt_o); end
    tick();
    line_ready_i = 1'b0;
    #1;
    n_tests++; if ({gnt_o, line_valid_o} !== 2'b10) begin n_fail++; $display("FAIL done_req gnt next cycle: got gnt=%0b valid=%0b expected 1/0", gnt_o, line_valid_o); end
    tick();
    req_i = 1'b0;
    #1;
    n_tests++; if ({rd_req_o, rd_addr_o, rd_id_o} !== {1'b1, 64'h5100, 4'h5}) begin
      n_fail++; $display("FAIL done_req new request: got req=%0b addr=%0h id=%0h expected 1/5100/5", rd_req_o, rd_addr_o, rd_id_o);
    end
    rd_gnt_i = 1'b1; tick(); rd_gnt_i = 1'b0;
    clear_beats();
    push_beat(64'h5A, 64'h7, 1'b1, 1'b1, 4'h5);
    model(2'd0, 4'h5, 1'b0);
    rd_valid_i = 1'b1; rd_data_i = 64'h5A; rd_user_i = 64'h7; rd_exokay_i = 1'b1; rd_last_i = 1'b1; rd_id_i = 4'h5;
    tick();
    rd_valid_i = 1'b0; rd_last_i = 1'b0;
    check_line("done_req_line", 4'h5);
    line_ready_i = 1'b1; tick(); line_ready_i = 1'b0;
  endtask

  task automatic test_reset_abort();
    addr_i = 64'h6000; blen_i = 2'd3; id_i = 4'h7; lock_i = 1'b1; req_i = 1'b1;
    tick(); req_i = 1'b0;
    rd_gnt_i = 1'b1; tick(); rd_gnt_i = 1'b0;
    rd_valid_i = 1'b1; rd_data_i = 64'hDEAD; rd_user_i = 64'h1; rd_exokay_i = 1'b1; rd_id_i = 4'h7;
    tick();
    rst_i = 1'b1; rd_valid_i = 1'b0;
    tick();
    n_tests++; if ({rd_rdy_o, line_valid_o, line_data_o, line_exokay_o, rd_addr_o} !== '0) begin
      n_fail++; $display("FAIL reset_abort: got rdy=%0b valid=%0b data=%0h exokay=%0b expected all 0", rd_rdy_o, line_valid_o, line_data_o, line_exokay_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] bl;
    logic [3:0] id;
    int nb;
    for (int t = 0; t < 25; t++) begin
      bl = 2'($urandom_range(0, 3));
      nb = $urandom_range(1, 6);
      id = 4'($urandom);
      clear_beats();
      for (int i = 0; i < nb; i++) begin
`ifdef AXI_RD_COLLECT_IDCHK_EN
        if ($urandom_range(0, 4) == 0)
          push_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), id ^ 4'h1);
        push_beat({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3) != 0, i == nb - 1, id);
`else
        push_beat({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3) != 0, i == nb - 1, 4'($urandom));
`endif
      end
      run_txn("random", {$urandom, $urandom}, bl, 3'($urandom), id, 1'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
  endtask

`ifdef AXI_RD_COLLECT_IDCHK_EN
  task automatic test_idchk();
    clear_beats();
    push_beat(64'h11, 64'h1, 1'b1, 1'b0, 4'h2);
    push_beat(64'h22, 64'h2, 1'b1, 1'b0, 4'h2);
    push_beat(64'hEE, 64'hE, 1'b1, 1'b1, 4'h3);
    push_beat(64'h33, 64'h3, 1'b1, 1'b0, 4'h2);
    push_beat(64'h44, 64'h4, 1'b1, 1'b1, 4'h2);
    run_txn("idchk", 64'h7000, 2'd3, 3'd3, 4'h2, 1'b0, 0, 0, 1'b0);
    n_tests++; if (exp_data !== {64'h44, 64'h33, 64'h22, 64'h11} || exp_err !== 1'b1) begin
      n_fail++; $display("FAIL idchk model: got %0h err=%0b expected 44_33_22_11 err=1", exp_data, exp_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_burst4();
    n_tests++; if (exp_data !== {64'h44, 64'h33, 64'h22, 64'h11}) begin
      n_fail++; $display("FAIL burst4 reference: got %0h expected 44_33_22_11", exp_data);
    end
    test_single();
    test_exclusive();
    test_short_long();
    test_req_during_done();
    test_reset_abort();
`ifdef AXI_RD_COLLECT_IDCHK_EN
    test_idchk();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
